// File: rtl/vt_rng_pkg.sv
// vt_rng shared constants and helpers.
// Seed mixing and xorshift32 step for the multi-channel generator.
package vt_rng_pkg;

  localparam logic [31:0] GOLDEN = 32'h9E37_79B9;
  localparam int SH_A = 13;
  localparam int SH_B = 17;
  localparam int SH_C = 5;
  localparam int G_OFS = 510;

  typedef enum logic {
    MODE_UNI   = 1'b0,
    MODE_GAUSS = 1'b1
  } mode_t;

  // Zero is a fixed point of xorshift, so it is never allowed as state.
  function automatic logic [31:0] seed_mix(
    input logic [31:0] s,
    input logic [31:0] c
  );
    logic [31:0] v;
    v = s ^ (c * GOLDEN);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  function automatic logic [31:0] xs_step(
    input logic [31:0] s
  );
    logic [31:0] v;
    v = s;
    v = v ^ (v << SH_A);
    v = v ^ (v >> SH_B);
    v = v ^ (v << SH_C);
    return v;
  endfunction

endpackage

// File: rtl/vt_rng_core.sv
// One xorshift32 channel: state, reseed, step.
// Exposes uniform and Irwin-Hall mappings of the current state.
import vt_rng_pkg::*;

module vt_rng_core #(
  parameter int          OUT_W        = 18,
  parameter logic [31:0] CH           = 32'd0,
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [31:0]      seed,
  output logic [OUT_W-1:0] uni,
  output logic [OUT_W-1:0] gauss
);

  logic [31:0]             st;
  logic [10:0]             g;
  logic signed [OUT_W-1:0] gs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= seed_mix(SEED_DEFAULT, CH);
    end else if (load) begin
      st <= seed_mix(seed, CH);
    end else if (step) begin
      st <= xs_step(st);
    end
  end

  assign uni = st[31 -: OUT_W];

  // Byte sum is at most 1020, so 11 bits hold it before the offset.
  assign g = 11'(st[7:0]) + 11'(st[15:8])
           + 11'(st[23:16]) + 11'(st[31:24])
           - 11'(G_OFS);

  assign gs    = OUT_W'($signed(g));
  assign gauss = gs <<< (OUT_W - 11);

endmodule

// File: rtl/vt_rng_mc.sv
// Multi-channel variate generator top.
// Handshake, output register, mode mux and sample counter.
import vt_rng_pkg::*;

module vt_rng_mc #(
  parameter int          NCH          = 4,
  parameter int          OUT_W        = 18,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [31:0]          seed,
  input  logic                 mode,
  input  logic                 en,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [NCH*OUT_W-1:0] x,
  output logic [CNT_W-1:0]     count
);

  logic                 advance;
  logic [NCH*OUT_W-1:0] nxt;
  logic                 gsel;

  assign advance = en & (~out_valid | out_ready) & ~load;
  assign gsel    = (mode_t'(mode) == MODE_GAUSS);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [OUT_W-1:0] uni;
    logic [OUT_W-1:0] gauss;

    vt_rng_core #(
      .OUT_W        (OUT_W),
      .CH           (32'(c)),
      .SEED_DEFAULT (SEED_DEFAULT)
    ) u_core (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .step  (advance),
      .seed  (seed),
      .uni   (uni),
      .gauss (gauss)
    );

    assign nxt[c*OUT_W +: OUT_W] = gsel ? gauss : uni;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      x         <= '0;
      count     <= '0;
    end else if (load) begin
      out_valid <= 1'b0;
      count     <= '0;
    end else if (advance) begin
      x         <= nxt;
      out_valid <= 1'b1;
      count     <= count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
